// File: rtl/dense_accumulate.sv
// Sequential fully-connected layer: one signed MAC per cycle computes `size`
// neuron pre-activations and presents them packed in the sigmoid input layout.
module dense_accumulate #(
  parameter int data_size = 4,
  parameter int in_size   = 3,
  parameter int size      = 3,
  parameter int frac_bits = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [data_size*in_size-1:0]      input_stream,
  input  logic [data_size*in_size*size-1:0] weight_stream,
  input  logic [data_size*size-1:0]         bias_stream,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [data_size*size-1:0]         output_stream,
  output logic [1:0]                        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready/valid here come only from the state register, and the
  // result stays frozen while out_valid is high and out_ready is low.

  localparam int ACC_W = 2*data_size + $clog2(in_size) + 1;
  localparam int K_W   = (in_size > 1) ? $clog2(in_size) : 1;
  localparam int N_W   = (size > 1) ? $clog2(size) : 1;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam logic [K_W-1:0] K_LAST  = K_W'(in_size - 1);
  localparam logic [N_W-1:0] N_LAST  = N_W'(size - 1);
  localparam acc_t           SAT_MAX = acc_t'((2**(data_size-1)) - 1);
  localparam acc_t           SAT_MIN = acc_t'(-(2**(data_size-1)));

  state_t                       state_q, state_d;
  logic [N_W-1:0]               n_q, n_d;
  logic [K_W-1:0]               k_q, k_d;
  acc_t                         acc_q, acc_d;
  logic signed [data_size-1:0]  x_q [in_size];
  logic signed [data_size-1:0]  x_d [in_size];
  logic signed [data_size-1:0]  w_q [size][in_size];
  logic signed [data_size-1:0]  w_d [size][in_size];
  logic signed [data_size-1:0]  b_q [size];
  logic signed [data_size-1:0]  b_d [size];
  logic signed [data_size-1:0]  y_q [size];
  logic signed [data_size-1:0]  y_d [size];

  logic signed [2*data_size-1:0] prod;
  acc_t                          sum;
  acc_t                          shifted;
  logic signed [data_size-1:0]   y_new;

  always_comb begin
    prod    = x_q[k_q] * w_q[n_q][k_q];
    sum     = acc_q + acc_t'(prod);
    shifted = sum >>> frac_bits;
    if (shifted > SAT_MAX)      y_new = SAT_MAX[data_size-1:0];
    else if (shifted < SAT_MIN) y_new = SAT_MIN[data_size-1:0];
    else                        y_new = shifted[data_size-1:0];
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    acc_d   = acc_q;
    x_d     = x_q;
    w_d     = w_q;
    b_d     = b_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < in_size; i++)
            x_d[i] = input_stream[i*data_size +: data_size];
          for (int n = 0; n < size; n++) begin
            b_d[n] = bias_stream[n*data_size +: data_size];
            for (int i = 0; i < in_size; i++)
              w_d[n][i] = weight_stream[(n*in_size+i)*data_size +: data_size];
          end
          n_d     = '0;
          k_d     = '0;
          acc_d   = acc_t'($signed(bias_stream[data_size-1:0])) <<< frac_bits;
          state_d = MAC;
        end
      end
      MAC: begin
        if (k_q == K_LAST) begin
          y_d[n_q] = y_new;
          k_d      = '0;
          if (n_q == N_LAST) begin
            n_d     = '0;
            acc_d   = '0;
            state_d = DONE;
          end else begin
            n_d   = n_q + 1'b1;
            acc_d = acc_t'(b_q[n_q + 1'b1]) <<< frac_bits;
          end
        end else begin
          acc_d = sum;
          k_d   = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      x_q     <= '{default: '0};
      w_q     <= '{default: '0};
      b_q     <= '{default: '0};
      y_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      w_q     <= w_d;
      b_q     <= b_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    output_stream = '0;
    for (int n = 0; n < size; n++)
      output_stream[n*data_size +: data_size] = y_q[n];
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dense_accumulate.sv
// Directed and randomized checks of dense_accumulate against a plain
// arithmetic model of the layer (bias + dot product, shift, saturate).
module tb_dense_accumulate;
  localparam int DS = 4;
  localparam int IS = 3;
  localparam int SZ = 3;
  localparam int FB = 0;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [DS*IS-1:0]       input_stream;
  logic [DS*IS*SZ-1:0]    weight_stream;
  logic [DS*SZ-1:0]       bias_stream;
  logic                   out_valid;
  logic                   out_ready;
  logic [DS*SZ-1:0]       output_stream;
  logic [1:0]             state_dbg;

  logic signed [DS-1:0] vx [IS];
  logic signed [DS-1:0] vw [SZ*IS];
  logic signed [DS-1:0] vb [SZ];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dense_accumulate #(.data_size(DS), .in_size(IS), .size(SZ), .frac_bits(FB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_stream(input_stream), .weight_stream(weight_stream),
    .bias_stream(bias_stream), .out_valid(out_valid), .out_ready(out_ready),
    .output_stream(output_stream), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DS*SZ-1:0] model_out();
    logic [DS*SZ-1:0] r;
    int acc;
    r = '0;
    for (int n = 0; n < SZ; n++) begin
      acc = int'(vb[n]) <<< FB;
      for (int k = 0; k < IS; k++) acc += int'(vx[k]) * int'(vw[n*IS+k]);
      acc = acc >>> FB;
      if (acc > 7)  acc = 7;
      if (acc < -8) acc = -8;
      r[n*DS +: DS] = acc[DS-1:0];
    end
    return r;
  endfunction

  task automatic rand_vec();
    for (int k = 0; k < IS; k++)      vx[k] = 4'($urandom_range(15, 0));
    for (int i = 0; i < SZ*IS; i++)   vw[i] = 4'($urandom_range(15, 0));
    for (int n = 0; n < SZ; n++)      vb[n] = 4'($urandom_range(15, 0));
  endtask

  // Present the current vector for one accept edge.
  task automatic apply();
    for (int k = 0; k < IS; k++)    input_stream[k*DS +: DS] = vx[k];
    for (int i = 0; i < SZ*IS; i++) weight_stream[i*DS +: DS] = vw[i];
    for (int n = 0; n < SZ; n++)    bias_stream[n*DS +: DS] = vb[n];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit scramble, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (scramble) begin
        input_stream  = DS*IS'($urandom);
        weight_stream = {$urandom, $urandom};
        bias_stream   = DS*SZ'($urandom);
      end
    end while (!out_valid && cnt < 20);
  endtask

  task automatic run_check(input string tag, input logic [DS*SZ-1:0] exp, input bit scramble);
    int cnt;
    apply();
    wait_done(scramble, cnt);
    check({tag, " latency"}, cnt, 9);
    check({tag, " result"}, output_stream, exp);
    tick();
    check({tag, " valid one cycle"}, out_valid, 1'b0);
    check({tag, " in_ready back"}, in_ready, 1'b1);
  endtask

  initial begin
    int cnt;
    logic [DS*SZ-1:0] exp;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    input_stream = '0; weight_stream = '0; bias_stream = '0;
    #12;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset output", output_stream, 12'h000);
    tick();
    reset = 1'b0;
    tick();

    vx = '{4'sd1, 4'sd2, 4'sd3};
    vw = '{4'sd1, 4'sd1, 4'sd1, -4'sd1, 4'sd0, 4'sd0, 4'sd2, 4'sd2, 4'sd2};
    vb = '{4'sd0, 4'sd0, 4'sd0};
    run_check("basic", 12'h7F6, 1'b0);

    vx = '{-4'sd8, -4'sd8, -4'sd8};
    for (int i = 0; i < SZ*IS; i++) vw[i] = 4'sd7;
    vb = '{4'sd1, 4'sd0, -4'sd1};
    run_check("neg_sat", 12'h888, 1'b0);

    for (int i = 0; i < SZ*IS; i++) vw[i] = 4'sd0;
    vb = '{4'sd3, -4'sd2, 4'sd5};
    run_check("bias_only", 12'h5E3, 1'b0);

    // Backpressure: result held, new input ignored while DONE.
    rand_vec();
    exp = model_out();
    out_ready = 1'b0;
    apply();
    wait_done(1'b0, cnt);
    check("bp latency", cnt, 9);
    check("bp result", output_stream, exp);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      input_stream = DS*IS'($urandom);
      tick();
      check("bp out_valid held", out_valid, 1'b1);
      check("bp output held", output_stream, exp);
      check("bp in_ready low", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp release in_ready", in_ready, 1'b1);
    check("bp release out_valid", out_valid, 1'b0);
    tick();
    check("bp no stray accept", in_ready, 1'b1);

    rand_vec();
    run_check("scramble", model_out(), 1'b1);

    // Reset four cycles after accept.
    rand_vec();
    apply();
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset output", output_stream, 12'h000);
    check("midreset in_ready", in_ready, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    rand_vec();
    run_check("after_reset", model_out(), 1'b0);

    for (int r = 0; r < 8; r++) begin
      rand_vec();
      run_check("random", model_out(), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
